// File: rtl/cpu_pkg.sv
// cpu_pkg: shared op encodings, FSM states and iteration count for the multiply/divide unit
package cpu_pkg;

    localparam logic [1:0] OP_MULTU = 2'b00;
    localparam logic [1:0] OP_DIVU  = 2'b01;
    localparam logic [1:0] OP_MULT  = 2'b10;
    localparam logic [1:0] OP_DIV   = 2'b11;

    localparam int MD_ITER  = 32;
    localparam int MD_CNT_W = $clog2(MD_ITER);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_FIN  = 2'b10
    } md_state_t;

    function automatic logic op_is_div(input logic [1:0] op);
        return (op == OP_DIVU) || (op == OP_DIV);
    endfunction

    function automatic logic op_is_signed(input logic [1:0] op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// muldiv_unit_if: request, MTHI/MTLO and HI/LO result signals of the multiply/divide unit
interface muldiv_unit_if;
    logic        start;
    logic [1:0]  op;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] w_data;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;

    modport master (
        output start, op, rs_data, rt_data, hi_we, lo_we, w_data,
        input  hi, lo, busy, done
    );

    modport slave (
        input  start, op, rs_data, rt_data, hi_we, lo_we, w_data,
        output hi, lo, busy, done
    );
endinterface

// File: rtl/muldiv_core.sv
// muldiv_core: iterative datapath, one shift-add (multiply) or restoring shift-subtract (divide) step per cycle
module muldiv_core
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_load,
    input  logic        i_step,
    input  logic        i_div,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    output logic [31:0] o_hi,
    output logic [31:0] o_lo,
    output logic        o_last
);

    logic [31:0]         r_hi;
    logic [31:0]         r_lo;
    logic [31:0]         r_b;
    logic                r_div;
    logic [MD_CNT_W-1:0] r_cnt;
    logic [32:0]         w_lhs;
    logic [33:0]         w_rhs;
    logic [33:0]         w_sum;
    logic [32:0]         w_mul_p;
    logic                w_div_ok;

    // Shared adder: multiply adds the multiplicand to the partial product, divide subtracts the
    // divisor from the remainder shifted left by one dividend bit.
    assign w_lhs    = r_div ? {r_hi, r_lo[31]} : {1'b0, r_hi};
    assign w_rhs    = r_div ? -{2'b00, r_b} : {2'b00, r_b};
    assign w_sum    = {1'b0, w_lhs} + w_rhs;
    assign w_mul_p  = r_lo[0] ? w_sum[32:0] : {1'b0, r_hi};
    assign w_div_ok = !w_sum[33];

    // Operand load on accept, then one iteration per step; a zero divisor naturally yields
    // an all-ones quotient and the dividend as remainder.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hi  <= '0;
            r_lo  <= '0;
            r_b   <= '0;
            r_div <= 1'b0;
            r_cnt <= '0;
        end else if (i_load) begin
            r_hi  <= '0;
            r_lo  <= i_a;
            r_b   <= i_b;
            r_div <= i_div;
            r_cnt <= '0;
        end else if (i_step) begin
            r_cnt <= r_cnt + 1'b1;
            if (r_div) begin
                r_hi <= w_div_ok ? w_sum[31:0] : w_lhs[31:0];
                r_lo <= {r_lo[30:0], w_div_ok};
            end else begin
                {r_hi, r_lo} <= {w_mul_p, r_lo[31:1]};
            end
        end
    end

    assign o_hi   = r_hi;
    assign o_lo   = r_lo;
    assign o_last = r_cnt == MD_CNT_W'(MD_ITER - 1);

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: MIPS-style HI/LO multiply/divide unit with MTHI/MTLO; define MULDIV_SIGNED_EN for signed MULT/DIV
module muldiv_unit
    import cpu_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    muldiv_unit_if.slave bus
);

    md_state_t   r_state;
    md_state_t   w_next;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic        r_done;
    logic        w_idle;
    logic        w_accept;
    logic        w_step;
    logic        w_fin;
    logic        w_last;
    logic        w_op_div;
    logic [31:0] w_a;
    logic [31:0] w_b;
    logic [31:0] w_core_hi;
    logic [31:0] w_core_lo;
    logic [31:0] w_res_hi;
    logic [31:0] w_res_lo;

    assign w_idle   = r_state == ST_IDLE;
    assign w_accept = w_idle && bus.start;
    assign w_step   = r_state == ST_RUN;
    assign w_fin    = r_state == ST_FIN;
    assign w_op_div = op_is_div(bus.op);

`ifdef MULDIV_SIGNED_EN
    logic        w_sgn;
    logic        w_a_neg;
    logic        w_b_neg;
    logic        r_is_div;
    logic        r_neg_q;
    logic        r_neg_r;
    logic [63:0] w_prod;

    assign w_sgn   = op_is_signed(bus.op);
    assign w_a_neg = w_sgn && bus.rs_data[31];
    assign w_b_neg = w_sgn && bus.rt_data[31];
    assign w_a     = w_a_neg ? -bus.rs_data : bus.rs_data;
    assign w_b     = w_b_neg ? -bus.rt_data : bus.rt_data;

    // Capture result sign fix-ups on accept; a zero divisor keeps the all-ones quotient
    // and the dividend-signed remainder so HI returns the original dividend.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_is_div <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
        end else if (w_accept) begin
            r_is_div <= w_op_div;
            r_neg_q  <= (w_a_neg ^ w_b_neg) && !(w_op_div && bus.rt_data == '0);
            r_neg_r  <= w_a_neg;
        end
    end

    assign w_prod   = r_neg_q ? -{w_core_hi, w_core_lo} : {w_core_hi, w_core_lo};
    assign w_res_hi = r_is_div ? (r_neg_r ? -w_core_hi : w_core_hi) : w_prod[63:32];
    assign w_res_lo = r_is_div ? (r_neg_q ? -w_core_lo : w_core_lo) : w_prod[31:0];
`else
    assign w_a      = bus.rs_data;
    assign w_b      = bus.rt_data;
    assign w_res_hi = w_core_hi;
    assign w_res_lo = w_core_lo;
`endif

    muldiv_core u_core (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_load (w_accept),
        .i_step (w_step),
        .i_div  (w_op_div),
        .i_a    (w_a),
        .i_b    (w_b),
        .o_hi   (w_core_hi),
        .o_lo   (w_core_lo),
        .o_last (w_last)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_next;
    end

    // Next state: start only matters in IDLE, RUN lasts exactly the iteration count.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: w_next = bus.start ? ST_RUN : ST_IDLE;
            ST_RUN:  w_next = w_last ? ST_FIN : ST_RUN;
            ST_FIN:  w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    // HI/LO update: result at FIN, MTHI/MTLO only in IDLE and lost to a coinciding start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hi   <= '0;
            r_lo   <= '0;
            r_done <= 1'b0;
        end else begin
            r_done <= w_fin;
            if (w_fin) begin
                r_hi <= w_res_hi;
                r_lo <= w_res_lo;
            end else if (w_idle && !bus.start) begin
                if (bus.hi_we) r_hi <= bus.w_data;
                if (bus.lo_we) r_lo <= bus.w_data;
            end
        end
    end

    assign bus.hi   = r_hi;
    assign bus.lo   = r_lo;
    assign bus.busy = !w_idle;
    assign bus.done = r_done;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: table-driven scoreboard bench for muldiv_unit (expectations follow MULDIV_SIGNED_EN)
module tb_muldiv_unit;
    import cpu_pkg::*;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        int          poke;
        bit          co;
    } vec_t;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    int          n_checks = 0;
    int          n_fail = 0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;
    exp_t        sb[$];
    vec_t        tbl[12];

    always #5 clk = ~clk;

    muldiv_unit_if bus();

    muldiv_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic   sg;
        longint sa;
        longint sbv;
`ifdef MULDIV_SIGNED_EN
        sg = op[1];
`else
        sg = 1'b0;
`endif
        sa  = sg ? longint'($signed(a)) : longint'({32'b0, a});
        sbv = sg ? longint'($signed(b)) : longint'({32'b0, b});
        if (!op[0]) return 64'(sa * sbv);
        if (b == '0) return {a, 32'hFFFFFFFF};
        return {32'(sa % sbv), 32'(sa / sbv)};
    endfunction

    task automatic run_op(input vec_t v);
        int   n;
        exp_t e;
        @(negedge clk);
        bus.start   = 1'b1;
        bus.op      = v.op;
        bus.rs_data = v.a;
        bus.rt_data = v.b;
        if (v.co) begin
            bus.hi_we  = 1'b1;
            bus.lo_we  = 1'b1;
            bus.w_data = 32'hDEADBEEF;
        end
        sb.push_back('{v.hi, v.lo});
        @(negedge clk);
        bus.start   = 1'b0;
        bus.hi_we   = 1'b0;
        bus.lo_we   = 1'b0;
        bus.op      = ~v.op;
        bus.rs_data = ~v.a;
        bus.rt_data = ~v.b;
        n = 0;
        check("busy_after_accept", 64'(bus.busy), 64'd1);
        if (v.co) check("we_dropped_on_start", {bus.hi, bus.lo}, {m_hi, m_lo});
        while (!bus.done && n < 40) begin
            if (n == v.poke) begin
                bus.start   = 1'b1;
                bus.op      = OP_MULTU;
                bus.rs_data = 32'd3;
                bus.rt_data = 32'd3;
                bus.hi_we   = 1'b1;
                bus.w_data  = 32'hA5A5A5A5;
            end
            @(negedge clk);
            n++;
            if (n == v.poke + 1) begin
                bus.start = 1'b0;
                bus.hi_we = 1'b0;
                check("hold_after_busy_poke", {bus.hi, bus.lo}, {m_hi, m_lo});
            end
            if (n == 16) begin
                check("hold_during_run", {bus.hi, bus.lo}, {m_hi, m_lo});
                check("busy_mid_run", 64'(bus.busy), 64'd1);
            end
        end
        check("done_latency", 64'(n), 64'd33);
        if (sb.size() == 0) begin
            check("scoreboard_empty", 64'd0, 64'd1);
        end else begin
            e = sb.pop_front();
            check("result_hi_lo", {bus.hi, bus.lo}, {e.hi, e.lo});
            m_hi = e.hi;
            m_lo = e.lo;
        end
        check("busy_at_done", 64'(bus.busy), 64'd0);
        @(negedge clk);
        check("done_pulse_width", 64'(bus.done), 64'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation still running, required finish");
        $fatal(1);
    end

    initial begin
        logic [63:0] m;
        int          pulses;
        logic [1:0]  rop;
        logic [31:0] ra;
        logic [31:0] rb;

        tbl[0] = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, -1, 1'b0};
        tbl[1] = '{OP_DIVU,  32'd100,      32'd7,        32'd2,        32'd14,       5,  1'b0};
        tbl[2] = '{OP_DIVU,  32'd5,        32'd0,        32'd5,        32'hFFFFFFFF, -1, 1'b0};
`ifdef MULDIV_SIGNED_EN
        tbl[3] = '{OP_MULT,  32'hFFFFFFFD, 32'd4,        32'hFFFFFFFF, 32'hFFFFFFF4, -1, 1'b0};
        tbl[4] = '{OP_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, -1, 1'b0};
`else
        tbl[3] = '{OP_MULT,  32'hFFFFFFFD, 32'd4,        32'h00000003, 32'hFFFFFFF4, -1, 1'b0};
        tbl[4] = '{OP_DIV,   32'hFFFFFFF9, 32'd2,        32'h00000001, 32'h7FFFFFFC, -1, 1'b0};
`endif
        tbl[5] = '{OP_DIVU,  32'hFFFFFFFF, 32'd1,        32'd0,        32'hFFFFFFFF, -1, 1'b0};
        tbl[6] = '{OP_MULTU, 32'd0,        32'h12345678, 32'd0,        32'd0,        -1, 1'b0};
        tbl[7] = '{OP_DIVU,  32'd3,        32'd10,       32'd3,        32'd0,        -1, 1'b1};
        tbl[8] = '{OP_DIV,   32'h80000000, 32'd0,        32'h80000000, 32'hFFFFFFFF, -1, 1'b0};
        for (int i = 9; i < 12; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = $urandom;
            rb  = $urandom | 32'h1;
            m   = model(rop, ra, rb);
            tbl[i] = '{rop, ra, rb, m[63:32], m[31:0], -1, 1'b0};
        end

        bus.start   = 1'b0;
        bus.op      = '0;
        bus.rs_data = '0;
        bus.rt_data = '0;
        bus.hi_we   = 1'b0;
        bus.lo_we   = 1'b0;
        bus.w_data  = '0;

        #2 rst_n = 1'b0;
        #1;
        check("reset_hi", 64'(bus.hi), 64'd0);
        check("reset_lo", 64'(bus.lo), 64'd0);
        check("reset_busy", 64'(bus.busy), 64'd0);
        check("reset_done", 64'(bus.done), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        @(negedge clk);
        bus.hi_we  = 1'b1;
        bus.w_data = 32'hA5A5A5A5;
        @(negedge clk);
        bus.hi_we = 1'b0;
        check("mthi", {bus.hi, bus.lo}, {32'hA5A5A5A5, m_lo});
        m_hi = 32'hA5A5A5A5;
        bus.hi_we  = 1'b1;
        bus.lo_we  = 1'b1;
        bus.w_data = 32'h13579BDF;
        @(negedge clk);
        bus.hi_we = 1'b0;
        bus.lo_we = 1'b0;
        check("mthi_mtlo_together", {bus.hi, bus.lo}, {32'h13579BDF, 32'h13579BDF});
        m_hi = 32'h13579BDF;
        m_lo = 32'h13579BDF;
        bus.lo_we  = 1'b1;
        bus.w_data = 32'h2468ACE0;
        @(negedge clk);
        bus.lo_we = 1'b0;
        check("mtlo", {bus.hi, bus.lo}, {m_hi, 32'h2468ACE0});
        m_lo = 32'h2468ACE0;

        for (int i = 0; i < 12; i++) run_op(tbl[i]);

        @(negedge clk);
        bus.start   = 1'b1;
        bus.op      = OP_DIVU;
        bus.rs_data = 32'd100;
        bus.rt_data = 32'd7;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (10) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrun_reset_busy", 64'(bus.busy), 64'd0);
        check("midrun_reset_hi_lo", {bus.hi, bus.lo}, 64'd0);
        check("midrun_reset_done", 64'(bus.done), 64'd0);
        m_hi = '0;
        m_lo = '0;
        @(negedge clk);
        rst_n  = 1'b1;
        pulses = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.done) pulses++;
        end
        check("no_done_after_reset", 64'(pulses), 64'd0);
        check("hi_lo_after_abandon", {bus.hi, bus.lo}, 64'd0);

        run_op('{OP_MULTU, 32'd7, 32'd6, 32'd0, 32'd42, -1, 1'b0});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
